// File: rtl/ar_pkg.sv
// Shared definitions for the bipolar RZ serial link (receiver and transmitter):
// word layout, line rates, receiver states and the bit-period helper.
package ar_pkg;

  localparam int ADR_W  = 8;
  localparam int DAT_W  = 23;
  localparam int WORD_W = 32;

  localparam int unsigned RATE_1M   = 1_000_000;
  localparam int unsigned RATE_100K = 100_000;
  localparam int unsigned RATE_50K  = 50_000;
  localparam int unsigned RATE_12K5 = 12_500;

  typedef enum logic [1:0] {
    ST_WAIT_GAP,
    ST_IDLE,
    ST_RECV,
    ST_CHECK
  } rxd_state_e;

  // Bit period in clock cycles for the rate selected by nvel.
  function automatic int unsigned t_bit(input int unsigned f_clk, input logic [1:0] nvel);
    unique case (nvel)
      2'd0:    return f_clk / RATE_1M;
      2'd1:    return f_clk / RATE_100K;
      2'd2:    return f_clk / RATE_50K;
      default: return f_clk / RATE_12K5;
    endcase
  endfunction

endpackage

// File: rtl/ar_rxd_sync.sv
// Two-flop synchronizers for both RZ line inputs, plus the rising-edge detector
// on their OR that marks the start of every bit.
module ar_rxd_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic inp1,
  input  logic inp0,
  output logic bit_evt,
  output logic bit_val,
  output logic both_hi
);

  logic [1:0] inp1_sync_q, inp1_sync_d;
  logic [1:0] inp0_sync_q, inp0_sync_d;
  logic       or_prev_q, or_prev_d;
  logic       line_or;

  assign line_or = inp1_sync_q[1] | inp0_sync_q[1];

  always_comb begin
    inp1_sync_d = {inp1_sync_q[0], inp1};
    inp0_sync_d = {inp0_sync_q[0], inp0};
    or_prev_d   = line_or;
  end

  // NOTE: reset is sampled on the clock edge only, so it lives inside the clocked branch and not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inp1_sync_q <= '0;
      inp0_sync_q <= '0;
      or_prev_q   <= 1'b0;
    end else begin
      inp1_sync_q <= inp1_sync_d;
      inp0_sync_q <= inp0_sync_d;
      or_prev_q   <= or_prev_d;
    end
  end

  assign bit_evt = line_or & ~or_prev_q;
  assign bit_val = inp1_sync_q[1];
  assign both_hi = inp1_sync_q[1] & inp0_sync_q[1];

endmodule

// File: rtl/ar_rxd_ctrl.sv
// Bipolar RZ word receiver: gap framing, 32-bit shift-in, word check and error strobes.
// Define AR_RXD_PARITY_EN to require odd parity over the whole 32-bit word.
module ar_rxd_ctrl
  import ar_pkg::*;
#(
  parameter int unsigned F_CLK = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       Nvel,
  input  logic             Inp1,
  input  logic             Inp0,
  output logic [ADR_W-1:0] sr_adr,
  output logic [DAT_W-1:0] sr_dat,
  output logic             ok_rx,
  output logic             err_par,
  output logic             err_len,
  output logic             err_line,
  output logic             err_gap,
  output logic             busy
);

  logic bit_evt, bit_val, both_hi;

  ar_rxd_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .inp1   (Inp1),
    .inp0   (Inp0),
    .bit_evt(bit_evt),
    .bit_val(bit_val),
    .both_hi(both_hi)
  );

  rxd_state_e         state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [15:0]        tmo_q, tmo_d;
  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic [ADR_W-1:0]   sr_adr_q, sr_adr_d;
  logic [DAT_W-1:0]   sr_dat_q, sr_dat_d;
  logic               both_prev_q, both_prev_d;
  logic               ok_rx_q, ok_rx_d;
  logic               err_par_q, err_par_d;
  logic               err_len_q, err_len_d;
  logic               err_line_q, err_line_d;
  logic               err_gap_q, err_gap_d;

  int unsigned        gap_full;
  logic [15:0]        t_gap;
  logic               gap_expired;
  logic               word_ok;

  // Gap threshold saturates to the 16-bit timeout range for slow rates / fast clocks.
  always_comb begin
    gap_full = t_bit(F_CLK, Nvel) << 1;
    t_gap    = (gap_full > 32'd65535) ? 16'hFFFF : gap_full[15:0];
  end

  assign gap_expired = (tmo_q >= t_gap);

`ifdef AR_RXD_PARITY_EN
  assign word_ok = ^shreg_q;
`else
  assign word_ok = 1'b1;
`endif

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    sr_adr_d    = sr_adr_q;
    sr_dat_d    = sr_dat_q;
    both_prev_d = both_hi;
    ok_rx_d     = 1'b0;
    err_par_d   = 1'b0;
    err_len_d   = 1'b0;
    err_line_d  = 1'b0;
    err_gap_d   = 1'b0;
    tmo_d       = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;

    // tmo counts cycles elapsed since the most recent bit event.
    if (bit_evt) tmo_d = 16'd1;

    if (both_hi) begin
      // Strobe once per collision even if both lines stay high for a while.
      err_line_d = ~both_prev_q;
      tmo_d      = 16'd0;
      cnt_d      = 6'd0;
      state_d    = ST_WAIT_GAP;
    end else begin
      unique case (state_q)
        ST_WAIT_GAP: begin
          if (bit_evt)          err_gap_d = 1'b1;
          else if (gap_expired) state_d   = ST_IDLE;
        end
        ST_IDLE: begin
          if (bit_evt) begin
            shreg_d = {bit_val, shreg_q[WORD_W-1:1]};
            cnt_d   = 6'd1;
            state_d = ST_RECV;
          end
        end
        ST_RECV: begin
          if (cnt_q == 6'd32) begin
            state_d = ST_CHECK;
          end else if (bit_evt) begin
            shreg_d = {bit_val, shreg_q[WORD_W-1:1]};
            cnt_d   = cnt_q + 6'd1;
          end else if (gap_expired) begin
            err_len_d = 1'b1;
            cnt_d     = 6'd0;
            state_d   = ST_IDLE;
          end
        end
        ST_CHECK: begin
          if (word_ok) begin
            sr_adr_d = shreg_q[ADR_W-1:0];
            sr_dat_d = shreg_q[ADR_W +: DAT_W];
            ok_rx_d  = 1'b1;
          end else begin
            err_par_d = 1'b1;
          end
          cnt_d   = 6'd0;
          state_d = ST_WAIT_GAP;
        end
      endcase
    end
  end

  // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT_GAP;
      cnt_q       <= '0;
      tmo_q       <= '0;
      shreg_q     <= '0;
      sr_adr_q    <= '0;
      sr_dat_q    <= '0;
      both_prev_q <= 1'b0;
      ok_rx_q     <= 1'b0;
      err_par_q   <= 1'b0;
      err_len_q   <= 1'b0;
      err_line_q  <= 1'b0;
      err_gap_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      shreg_q     <= shreg_d;
      sr_adr_q    <= sr_adr_d;
      sr_dat_q    <= sr_dat_d;
      both_prev_q <= both_prev_d;
      ok_rx_q     <= ok_rx_d;
      err_par_q   <= err_par_d;
      err_len_q   <= err_len_d;
      err_line_q  <= err_line_d;
      err_gap_q   <= err_gap_d;
    end
  end

  assign sr_adr   = sr_adr_q;
  assign sr_dat   = sr_dat_q;
  assign ok_rx    = ok_rx_q;
  assign err_par  = err_par_q;
  assign err_len  = err_len_q;
  assign err_line = err_line_q;
  assign err_gap  = err_gap_q;
  assign busy     = (state_q == ST_RECV) || (state_q == ST_CHECK);

endmodule
